simple_merger: RTL and testbench

Four-input, one-output round-robin merger with valid/ready handshakes on every port. It is the return-path counterpart of the 2-bit-address router: the router fans one stream out to four destinations, and this block collects four source streams back into one. Each output beat carries the 2-bit index of its source port. The output is registered, so the block sits directly on the shared return bus.

---
 rtl/simple_merger.sv | 133 +++++++++++++
 tb/tb_simple_merger.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/simple_merger.sv
// rtl/simple_merger.sv - four-input round-robin merger with registered output stage
// Build option: SIMPLE_MERGER_FIXED_PRIO_EN selects fixed priority (port 0 highest).
module simple_merger #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic [3:0]            din_valid,
    output logic [3:0]            din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            dout_src,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [15:0]           xfer_count
);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [1:0]            dout_src_q, dout_src_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [15:0]           xfer_count_q, xfer_count_d;

    logic                  load;
    logic                  any_grant;
    logic [1:0]            grant_idx;
    logic [3:0]            grant;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef SIMPLE_MERGER_FIXED_PRIO_EN
    always_comb begin
        grant_idx = 2'd0;
        any_grant = |din_valid;
        for (int k = 3; k >= 0; k--) begin
            if (din_valid[k]) begin
                grant_idx = 2'(k);
            end
        end
    end
`else
    logic [1:0] last_q, last_d;
    logic [1:0] rr_idx;

    // Search starts just after the last granted port and wraps back to it.
    always_comb begin
        grant_idx = last_q;
        any_grant = 1'b0;
        rr_idx    = last_q;
        for (int k = 1; k < 5; k++) begin
            rr_idx = last_q + 2'(k);
            if (!any_grant && din_valid[rr_idx]) begin
                any_grant = 1'b1;
                grant_idx = rr_idx;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= 2'd3;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        grant = 4'b0000;
        if (any_grant) begin
            grant = 4'b0001 << grant_idx;
        end
    end

    assign load      = ~dout_valid_q | dout_ready;
    assign din_ready = resetn ? (grant & {4{load}}) : 4'b0000;
    assign xfer      = |(din_valid & din_ready);

    always_comb begin
        case (grant_idx)
            2'd0:    sel_data = din0;
            2'd1:    sel_data = din1;
            2'd2:    sel_data = din2;
            default: sel_data = din3;
        endcase
    end

    always_comb begin
        dout_d       = dout_q;
        dout_src_d   = dout_src_q;
        dout_valid_d = dout_valid_q;
        xfer_count_d = xfer_count_q;
        if (xfer) begin
            dout_d       = sel_data;
            dout_src_d   = grant_idx;
            dout_valid_d = 1'b1;
            if (xfer_count_q != 16'hFFFF) begin
                xfer_count_d = xfer_count_q + 16'd1;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout_q       <= '0;
            dout_src_q   <= 2'd0;
            dout_valid_q <= 1'b0;
            xfer_count_q <= 16'd0;
        end else begin
            dout_q       <= dout_d;
            dout_src_q   <= dout_src_d;
            dout_valid_q <= dout_valid_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign dout       = dout_q;
    assign dout_src   = dout_src_q;
    assign dout_valid = dout_valid_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_simple_merger.sv
// tb/tb_simple_merger.sv - table-driven bench for simple_merger
module tb_simple_merger;

`ifdef SIMPLE_MERGER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    localparam logic [31:0] D0 = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'hA5A5_0001;
    localparam logic [31:0] D2 = 32'hA5A5_0002;
    localparam logic [31:0] D3 = 32'hA5A5_0003;

    logic        clk;
    logic        resetn;
    logic [31:0] din0, din1, din2, din3;
    logic [3:0]  din_valid;
    logic [3:0]  din_ready;
    logic [31:0] dout;
    logic [1:0]  dout_src;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] xfer_count;

    int checks   = 0;
    int failures = 0;

    simple_merger #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_src   (dout_src),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .xfer_count (xfer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rstn;
        logic [3:0]  valid;
        logic        dready;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_src;
        logic [31:0] exp_dout;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mkv(logic rstn, logic [3:0] valid, logic dready, logic [3:0] exp_ready,
                                 logic exp_ov, logic [1:0] exp_src, logic [31:0] exp_dout,
                                 logic [15:0] exp_cnt);
        vec_t v;
        v.rstn = rstn; v.valid = valid; v.dready = dready; v.exp_ready = exp_ready;
        v.exp_ov = exp_ov; v.exp_src = exp_src; v.exp_dout = exp_dout; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    function automatic logic [31:0] data_of(logic [1:0] p);
        case (p)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] g;
        int         bad_ready;

        // reset, single beat from port 2, reset mid-stream with output full
        vecs[0] = mkv(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 16'd0);
        vecs[1] = mkv(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2, 16'd1);
        vecs[2] = mkv(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 16'd0);
        // all ports valid for 8 cycles straight out of reset
        for (int i = 0; i < 8; i++) begin
            g = FIXED ? 2'd0 : 2'(i);
            vecs[3+i] = mkv(1'b1, 4'b1111, 1'b1, 4'b0001 << g, 1'b1, g, data_of(g), 16'(i + 1));
        end
        g = FIXED ? 2'd0 : 2'd3;
        vecs[11] = mkv(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, g, data_of(g), 16'd8);
        // port 1 loads into an empty output while downstream stalls, then back-pressure
        vecs[12] = mkv(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, D1, 16'd9);
        vecs[13] = mkv(1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, D1, 16'd9);
        vecs[14] = mkv(1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, D1, 16'd9);
        vecs[15] = mkv(1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, D1, 16'd9);
        g = FIXED ? 2'd0 : 2'd3;
        vecs[16] = mkv(1'b1, 4'b1001, 1'b1, 4'b0001 << g, 1'b1, g, data_of(g), 16'd10);
        vecs[17] = mkv(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, g, data_of(g), 16'd10);
        vecs[18] = mkv(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, g, data_of(g), 16'd10);

        din0 = D0; din1 = D1; din2 = D2; din3 = D3;
        resetn = 1'b0; din_valid = 4'b0000; dout_ready = 1'b1;
        @(posedge clk); #1;
        chk("reset_dout_valid", {31'b0, dout_valid}, 32'd0);
        chk("reset_xfer_count", {16'b0, xfer_count}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            resetn     = vecs[i].rstn;
            din_valid  = vecs[i].valid;
            dout_ready = vecs[i].dready;
            #4;
            chk($sformatf("v%0d_din_ready", i), {28'b0, din_ready}, {28'b0, vecs[i].exp_ready});
            @(posedge clk); #1;
            chk($sformatf("v%0d_dout_valid", i), {31'b0, dout_valid}, {31'b0, vecs[i].exp_ov});
            chk($sformatf("v%0d_dout_src", i), {30'b0, dout_src}, {30'b0, vecs[i].exp_src});
            chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
            chk($sformatf("v%0d_xfer_count", i), {16'b0, xfer_count}, {16'b0, vecs[i].exp_cnt});
        end

        // saturation: port 0 streams continuously
        resetn = 1'b0; din_valid = 4'b0000; dout_ready = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b1; din_valid = 4'b0001;
        bad_ready = 0;
        for (int c = 0; c < 65534; c++) begin
            #4;
            if (din_ready !== 4'b0001) bad_ready++;
            @(posedge clk); #1;
        end
        chk("sat_ready_stream", bad_ready, 0);
        chk("sat_count_fffe", {16'b0, xfer_count}, 32'h0000_FFFE);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        chk("sat_count_ffff", {16'b0, xfer_count}, 32'h0000_FFFF);
        din0 = 32'h1234_5678;
        #4;
        chk("sat_din_ready", {28'b0, din_ready}, 32'd1);
        @(posedge clk); #1;
        chk("sat_count_hold", {16'b0, xfer_count}, 32'h0000_FFFF);
        chk("sat_dout", dout, 32'h1234_5678);
        chk("sat_dout_valid", {31'b0, dout_valid}, 32'd1);
        chk("sat_dout_src", {30'b0, dout_src}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
